// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN accelerator's memory-facing blocks.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 20;
    localparam int unsigned LEN_WIDTH  = 11;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        DONE
    } dma_arb_state_t;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } dma_desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, in cyclic order.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/dma_burst_arbiter.sv
// Shares the single DMA port among burst requesters: round-robin grant, then one
// word per cycle to/from memory, with read data streamed back a cycle after each beat.
module dma_burst_arbiter #(
    parameter int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned LEN_WIDTH  = cnn_pkg::LEN_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_rw,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]   req_len,
    output logic [NUM_REQ-1:0]                  req_ack,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wr_data,
    output logic [NUM_REQ-1:0]                  wr_beat,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic [NUM_REQ-1:0]                  rd_valid,
    output logic [NUM_REQ-1:0]                  done,
    output logic                                busy,
    output logic                                mem_en,
    output logic                                mem_rw,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    input  logic [DATA_WIDTH-1:0]               mem_rdata
);

    import cnn_pkg::*;

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    dma_arb_state_t        state_q;
    logic [NUM_REQ-1:0]    owner_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic [NUM_REQ-1:0]    req_ack_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    rd_valid_q;
    logic                  mem_en_q;
    logic                  mem_rw_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            req_ack_q  <= '0;
            done_q     <= '0;
            rd_valid_q <= '0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            // Memory returns read data one cycle after each read beat.
            rd_valid_q <= (mem_en_q && mem_rw_q) ? owner_q : '0;
            case (state_q)
                IDLE: begin
                    if (req_ack_q != '0) begin
                        // Ack cycle: descriptor already captured, start the burst.
                        req_ack_q <= '0;
                        if (len_q == '0) begin
                            state_q <= DONE;
                            done_q  <= owner_q;
                        end else begin
                            state_q    <= BURST;
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= rw_q;
                            mem_addr_q <= addr_q;
                            beat_q     <= '0;
                        end
                    end else if (gnt_valid) begin
                        req_ack_q <= gnt;
                        owner_q   <= gnt;
                        idx_q     <= gnt_idx;
                        rw_q      <= req_rw[gnt_idx];
                        addr_q    <= req_addr[gnt_idx];
                        len_q     <= req_len[gnt_idx];
                    end
                end
                BURST: begin
                    if (beat_q == len_q - LEN_WIDTH'(1)) begin
                        mem_en_q <= 1'b0;
                        mem_rw_q <= 1'b0;
                        if (rw_q == MEM_READ) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= DONE;
                            done_q  <= owner_q;
                        end
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                        beat_q     <= beat_q + LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    done_q  <= owner_q;
                end
                DONE: begin
                    done_q   <= '0;
                    rr_ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_beat   = '0;
        mem_wdata = '0;
        if (state_q == BURST && rw_q == MEM_WRITE) begin
            wr_beat   = owner_q;
            mem_wdata = wr_data[idx_q];
        end
    end

    assign req_ack  = req_ack_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = (rd_valid_q != '0) ? mem_rdata : '0;
    assign busy     = (state_q != IDLE);
    assign mem_en   = mem_en_q;
    assign mem_rw   = mem_rw_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_dma_burst_arbiter.sv
// Randomised bench for dma_burst_arbiter: a transaction-level model expands each round
// of requests into an expected per-cycle trace that the DUT outputs are compared against.
module tb_dma_burst_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int LW = 11;
    localparam int TMAX = 256;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_rw = '0;
    logic [N-1:0][AW-1:0] req_addr = '0;
    logic [N-1:0][LW-1:0] req_len = '0;
    logic [N-1:0]         req_ack;
    logic [N-1:0][DW-1:0] wr_data;
    logic [N-1:0]         wr_beat;
    logic [DW-1:0]        rd_data;
    logic [N-1:0]         rd_valid;
    logic [N-1:0]         done;
    logic                 busy;
    logic                 mem_en;
    logic                 mem_rw;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata = '0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dma_burst_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (N),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ack   (req_ack),
        .wr_data   (wr_data),
        .wr_beat   (wr_beat),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Requesters: each write stream is wbase + number of words already consumed.
    logic [DW-1:0] wcnt [N] = '{default: '0};

    function automatic logic [DW-1:0] wbase(input int r);
        return (r == 2) ? 16'h00A1 : DW'(16'h1000 * (r + 1));
    endfunction

    always_comb begin
        for (int r = 0; r < N; r++) wr_data[r] = wbase(r) + wcnt[r];
    end

    // Memory: 1-cycle read latency, data = low address bits.
    always @(posedge clk) begin
        for (int r = 0; r < N; r++) if (wr_beat[r]) wcnt[r] <= wcnt[r] + 1'b1;
        if (mem_en && mem_rw) mem_rdata <= mem_addr[DW-1:0];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]  ack, wbeat, rdv, dn;
        logic          en, rw, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rdata;
    } cyc_t;

    cyc_t          tr [TMAX];
    int            tr_len;
    int            p_m = 0;
    int            mcnt [N] = '{default: 0};
    bit            s_in [N];
    logic          d_rw [N];
    logic [AW-1:0] d_addr [N];
    int            d_len [N];
    int            ackc [N];

    task automatic clear_round();
        for (int r = 0; r < N; r++) begin
            s_in[r] = 1'b0;
            ackc[r] = 0;
        end
    endtask

    task automatic post(input int r, input logic rw, input logic [AW-1:0] addr, input int len);
        s_in[r]   = 1'b1;
        d_rw[r]   = rw;
        d_addr[r] = addr;
        d_len[r]  = len;
    endtask

    // Expand the posted descriptors into the cycle-by-cycle behaviour the spec describes.
    task automatic build();
        bit pend [N];
        int left, t, g, r, c, dn, len;
        for (int k = 0; k < TMAX; k++) tr[k] = '{default: '0};
        left = 0;
        for (int k = 0; k < N; k++) begin
            pend[k] = s_in[k];
            if (s_in[k]) left++;
        end
        t = 1;
        while (left > 0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                r = (p_m + k) % N;
                if (g < 0 && pend[r]) g = r;
            end
            pend[g] = 1'b0;
            left--;
            ackc[g] = t;
            tr[t].ack[g] = 1'b1;
            len = d_len[g];
            for (int i = 0; i < len; i++) begin
                c = t + 1 + i;
                tr[c].en   = 1'b1;
                tr[c].rw   = d_rw[g];
                tr[c].addr = d_addr[g] + AW'(i);
                if (d_rw[g]) begin
                    tr[c+1].rdv[g] = 1'b1;
                    tr[c+1].rdata  = tr[c].addr[DW-1:0];
                end else begin
                    tr[c].wbeat[g] = 1'b1;
                    tr[c].wdata    = wbase(g) + DW'(mcnt[g] + i);
                end
            end
            dn = (len == 0) ? t + 1 : (d_rw[g] ? t + len + 2 : t + len + 1);
            for (int k = t + 1; k <= dn; k++) tr[k].busy = 1'b1;
            tr[dn].dn[g] = 1'b1;
            if (!d_rw[g]) mcnt[g] += len;
            p_m = (g + 1) % N;
            t = dn + 2;
        end
        tr_len = t;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " req_ack"}, 64'(req_ack), 64'd0);
        check({tag, " wr_beat"}, 64'(wr_beat), 64'd0);
        check({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " mem_en"}, 64'(mem_en), 64'd0);
        check({tag, " mem_rw"}, 64'(mem_rw), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, " rd_data"}, 64'(rd_data), 64'd0);
    endtask

    task automatic compare(input string name, input int c);
        string p;
        p = $sformatf("%s c%0d", name, c);
        check({p, " req_ack"}, 64'(req_ack), 64'(tr[c].ack));
        check({p, " wr_beat"}, 64'(wr_beat), 64'(tr[c].wbeat));
        check({p, " rd_valid"}, 64'(rd_valid), 64'(tr[c].rdv));
        check({p, " done"}, 64'(done), 64'(tr[c].dn));
        check({p, " busy"}, 64'(busy), 64'(tr[c].busy));
        check({p, " mem_en"}, 64'(mem_en), 64'(tr[c].en));
        if (tr[c].en) begin
            check({p, " mem_addr"}, 64'(mem_addr), 64'(tr[c].addr));
            check({p, " mem_rw"}, 64'(mem_rw), 64'(tr[c].rw));
        end
        if (tr[c].wbeat != '0) check({p, " mem_wdata"}, 64'(mem_wdata), 64'(tr[c].wdata));
        if (tr[c].rdv != '0) check({p, " rd_data"}, 64'(rd_data), 64'(tr[c].rdata));
    endtask

    // Requesters hold their descriptor until the model's ack cycle, then scribble on it.
    task automatic run(input string name, input int abort_at);
        build();
        for (int c = 0; c < tr_len; c++) begin
            @(negedge clk);
            compare(name, c);
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero({name, " abort"});
                req_valid = '0;
                repeat (2) @(negedge clk);
                check_zero({name, " held"});
                rst_n = 1'b1;
                p_m = 0;
                return;
            end
            for (int r = 0; r < N; r++) begin
                if (s_in[r] && c < ackc[r]) begin
                    req_valid[r] = 1'b1;
                    req_rw[r]    = d_rw[r];
                    req_addr[r]  = d_addr[r];
                    req_len[r]   = LW'(d_len[r]);
                end else begin
                    req_valid[r] = 1'b0;
                    req_rw[r]    = 1'($urandom);
                    req_addr[r]  = AW'($urandom);
                    req_len[r]   = LW'($urandom);
                end
            end
        end
    endtask

    initial begin
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        clear_round(); post(0, 1'b1, 20'h00100, 4);       run("rd0", -1);
        clear_round(); post(2, 1'b0, 20'h00020, 3);       run("wr2", -1);
        for (int k = 0; k < 2; k++) begin
            clear_round();
            post(0, 1'b1, 20'h00200, 2);
            post(1, 1'b0, 20'h00300, 2);
            post(2, 1'b1, 20'h00400, 2);
            run("all3", -1);
        end
        clear_round(); post(1, 1'b1, 20'hFFFFE, 4);       run("wrap", -1);
        clear_round(); post(1, 1'b0, 20'h00055, 0);       run("len0", -1);

        for (int k = 0; k < 25; k++) begin
            int mask;
            mask = $urandom_range(1, 7);
            clear_round();
            for (int r = 0; r < N; r++) begin
                if (mask[r]) begin
                    post(r, 1'($urandom),
                         ($urandom_range(0, 3) == 0) ? AW'(20'hFFFFF - $urandom_range(0, 3))
                                                     : AW'($urandom),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1)
                                                     : $urandom_range(2, 12));
                end
            end
            run("rand", -1);
        end

        clear_round(); post(0, 1'b1, 20'h00500, 8);       run("abort", 4);
        clear_round();
        post(0, 1'b1, 20'h00600, 1);
        post(1, 1'b0, 20'h00700, 1);
        post(2, 1'b1, 20'h00800, 1);
        run("post_rst", -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
